// File: rtl/sprite_rect_drawer.sv
// Plots a WxH solid sprite one pixel per clock, column-major, with an optional
// background-colour trail erase (left column, right column or top row).
module sprite_rect_drawer #(
  parameter int W         = 4,
  parameter int H         = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int CW        = 3,
  parameter int BG_COLOUR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          start,
  input  logic [XW-1:0] sprite_x,
  input  logic [YW-1:0] sprite_y,
  input  logic [CW-1:0] colour,
  input  logic [1:0]    erase_mode,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          plot,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, FILL, ERASE, DONE} state_t;

  localparam logic [4:0]    WM1  = 5'(W - 1);
  localparam logic [4:0]    HM1  = 5'(H - 1);
  localparam logic [4:0]    WOFF = 5'(W);
  localparam logic [XW:0]   SWX  = SCREEN_W[XW:0];
  localparam logic [YW:0]   SHY  = SCREEN_H[YW:0];
  localparam int            XM   = SCREEN_W - 1;
  localparam int            YM   = SCREEN_H - 1;
  localparam logic [XW-1:0] XMAX = XM[XW-1:0];
  localparam logic [YW-1:0] YMAX = YM[YW-1:0];
  localparam logic [CW-1:0] BG   = BG_COLOUR[CW-1:0];

  // Single conditional subtraction: operands are always < 2x the modulus.
  function automatic logic [XW-1:0] wx(input logic [XW:0] s);
    logic [XW:0] d;
    d = s - SWX;
    return (s >= SWX) ? d[XW-1:0] : s[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] wy(input logic [YW:0] s);
    logic [YW:0] d;
    d = s - SHY;
    return (s >= SHY) ? d[YW-1:0] : s[YW-1:0];
  endfunction

  function automatic logic [XW-1:0] add_x(input logic [XW-1:0] b, input logic [4:0] off);
    return wx({1'b0, b} + {{(XW-4){1'b0}}, off});
  endfunction

  function automatic logic [YW-1:0] add_y(input logic [YW-1:0] b, input logic [4:0] off);
    return wy({1'b0, b} + {{(YW-4){1'b0}}, off});
  endfunction

  state_t        state, nxt_state;
  logic [4:0]    r, c, e, nxt_r, nxt_c, nxt_e;
  logic [XW-1:0] lx, bx, nx;
  logic [YW-1:0] ly, by, ny;
  logic [CW-1:0] lcol, bcol, ncol;
  logic [1:0]    lmode, bmode;
  logic          nplot, nbusy, ndone;

  // In IDLE the pixel being launched comes straight from the (reduced) pins.
  always_comb begin
    bx    = (state == IDLE) ? wx({1'b0, sprite_x}) : lx;
    by    = (state == IDLE) ? wy({1'b0, sprite_y}) : ly;
    bcol  = (state == IDLE) ? colour : lcol;
    bmode = (state == IDLE) ? erase_mode : lmode;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt_state;

  always_comb begin
    nxt_state = state;
    nxt_r = r;
    nxt_c = c;
    nxt_e = e;
    case (state)
      IDLE: if (start) begin
        nxt_state = FILL;
        nxt_r = '0;
        nxt_c = '0;
        nxt_e = '0;
      end
      FILL: if (r == HM1) begin
        nxt_r = '0;
        if (c == WM1) begin
          nxt_c = '0;
          nxt_e = '0;
          nxt_state = (lmode != 2'b00) ? ERASE : DONE;
        end else nxt_c = c + 5'd1;
      end else nxt_r = r + 5'd1;
      ERASE: if (e == ((lmode == 2'b11) ? WM1 : HM1)) begin
        nxt_e = '0;
        nxt_state = DONE;
      end else nxt_e = e + 5'd1;
      default: nxt_state = IDLE;
    endcase
    if (clear) begin
      nxt_state = IDLE;
      nxt_r = '0;
      nxt_c = '0;
      nxt_e = '0;
    end
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    nx = x_out;
    ny = y_out;
    ncol = colour_out;
    nplot = 1'b0;
    nbusy = 1'b0;
    ndone = 1'b0;
    case (nxt_state)
      FILL: begin
        nx = add_x(bx, nxt_c);
        ny = add_y(by, nxt_r);
        ncol = bcol;
        nplot = 1'b1;
        nbusy = 1'b1;
      end
      ERASE: begin
        ncol = BG;
        nplot = 1'b1;
        nbusy = 1'b1;
        case (bmode)
          2'b01: begin
            nx = (bx == '0) ? XMAX : bx - 1'b1;
            ny = add_y(by, nxt_e);
          end
          2'b10: begin
            nx = add_x(bx, WOFF);
            ny = add_y(by, nxt_e);
          end
          default: begin
            nx = add_x(bx, nxt_e);
            ny = (by == '0) ? YMAX : by - 1'b1;
          end
        endcase
      end
      DONE: ndone = 1'b1;
      default: ;
    endcase
    if (clear) begin
      nx = '0;
      ny = '0;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r <= '0; c <= '0; e <= '0;
      lx <= '0; ly <= '0; lcol <= '0; lmode <= '0;
      x_out <= '0; y_out <= '0; colour_out <= '0;
      plot <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      r <= nxt_r;
      c <= nxt_c;
      e <= nxt_e;
      if (!clear && state == IDLE && start) begin
        lx <= bx; ly <= by; lcol <= bcol; lmode <= bmode;
      end
      x_out <= nx;
      y_out <= ny;
      colour_out <= ncol;
      plot <= nplot;
      busy <= nbusy;
      done <= ndone;
    end
endmodule

// File: tb/tb_sprite_rect_drawer.sv
// Randomised bench for sprite_rect_drawer: a 4x4 and an 8x2 instance checked
// pixel-by-pixel against a list-based reference of the expected draw.
module tb_sprite_rect_drawer;
  logic clk = 0, reset = 0, clear = 0, start0 = 0, start1 = 0;
  logic [7:0] sprite_x = 0;
  logic [6:0] sprite_y = 0;
  logic [2:0] colour = 0;
  logic [1:0] erase_mode = 0;
  logic [7:0] x0, x1, ox;
  logic [6:0] y0, y1, oy;
  logic [2:0] c0, c1, oc;
  logic p0, p1, b0, b1, d0, d1, op, ob, od;
  int sel = 0;
  int checks = 0, failures = 0;

  sprite_rect_drawer u0 (
    .clk(clk), .reset(reset), .clear(clear), .start(start0),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .colour(colour), .erase_mode(erase_mode),
    .x_out(x0), .y_out(y0), .colour_out(c0), .plot(p0), .busy(b0), .done(d0));

  sprite_rect_drawer #(.W(8), .H(2)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .start(start1),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .colour(colour), .erase_mode(erase_mode),
    .x_out(x1), .y_out(y1), .colour_out(c1), .plot(p1), .busy(b1), .done(d1));

  always #5 clk = ~clk;

  always_comb begin
    ox = sel ? x1 : x0; oy = sel ? y1 : y0; oc = sel ? c1 : c0;
    op = sel ? p1 : p0; ob = sel ? b1 : b0; od = sel ? d1 : d0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else start1 = v;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_plot"}, op, 0); chk({tag, "_busy"}, ob, 0); chk({tag, "_done"}, od, 0);
    chk({tag, "_x"}, ox, 0); chk({tag, "_y"}, oy, 0); chk({tag, "_col"}, oc, 0);
  endtask

  // Called at posedge+1 with the selected instance idle.
  task automatic run_draw(input int s, input int sx, input int sy, input int col,
                          input int mode, input int w, input int h);
    int ex[$], ey[$], ec[$];
    int rx, ry, n;
    rx = (sx >= 160) ? sx - 160 : sx;
    ry = (sy >= 120) ? sy - 120 : sy;
    for (int cc = 0; cc < w; cc++)
      for (int rr = 0; rr < h; rr++) begin
        ex.push_back((rx + cc) % 160); ey.push_back((ry + rr) % 120); ec.push_back(col);
      end
    if (mode == 1 || mode == 2)
      for (int i = 0; i < h; i++) begin
        ex.push_back(mode == 1 ? (rx + 159) % 160 : (rx + w) % 160);
        ey.push_back((ry + i) % 120); ec.push_back(0);
      end
    if (mode == 3)
      for (int i = 0; i < w; i++) begin
        ex.push_back((rx + i) % 160); ey.push_back((ry + 119) % 120); ec.push_back(0);
      end
    n = ex.size();
    sel = s;
    sprite_x = 8'(sx); sprite_y = 7'(sy); colour = 3'(col); erase_mode = 2'(mode);
    set_start(s, 1);
    @(posedge clk); #1;
    set_start(s, 0);
    for (int i = 0; i < n; i++) begin
      chk("plot", op, 1); chk("busy", ob, 1); chk("done_early", od, 0);
      chk("px", ox, ex[i]); chk("py", oy, ey[i]); chk("pcol", oc, ec[i]);
      sprite_x = 8'($urandom); sprite_y = 7'($urandom); colour = 3'($urandom);
      erase_mode = 2'($urandom);
      set_start(s, (i < n - 1) && ($urandom_range(0, 3) == 0));
      @(posedge clk); #1;
    end
    set_start(s, 0);
    chk("done", od, 1); chk("done_plot", op, 0); chk("done_busy", ob, 0);
    @(posedge clk); #1;
    chk("done_once", od, 0); chk("idle_busy", ob, 0);
  endtask

  initial begin
    int dcount;
    #12;
    sel = 0; check_idle_zero("rst0");
    sel = 1; check_idle_zero("rst1");
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;

    run_draw(0, 10, 20, 4, 0, 4, 4);
    run_draw(0, 10, 20, 4, 1, 4, 4);
    run_draw(0, 158, 118, 5, 2, 4, 4);
    run_draw(0, 0, 0, 6, 3, 4, 4);

    // Abort on pixel 7: no done must follow.
    sel = 0;
    sprite_x = 8'd50; sprite_y = 7'd60; colour = 3'd7; erase_mode = 2'd1;
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_clear_plot", op, 1);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    chk("clr_plot", op, 0); chk("clr_busy", ob, 0); chk("clr_x", ox, 0); chk("clr_y", oy, 0);
    dcount = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (od) dcount++;
    end
    chk("clr_nodone", dcount, 0);

    repeat (20)
      run_draw(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 4, 4);

    // 8x2 instance: asynchronous reset mid-fill, then fresh draws.
    sel = 1;
    sprite_x = 8'd30; sprite_y = 7'd40; colour = 3'd3; erase_mode = 2'd0;
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_fill_plot", op, 1);
    reset = 0;
    #1;
    check_idle_zero("async_rst");
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    run_draw(1, 30, 40, 3, 0, 8, 2);
    run_draw(1, 155, 119, 2, 2, 8, 2);
    run_draw(1, 0, 0, 1, 3, 8, 2);
    repeat (6)
      run_draw(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_rect_drawer.md
Name: sprite_rect_drawer

Overview:
- Parametrised successor to the fixed 4x4 enemy drawers. Plots a WxH solid-colour sprite, one pixel per clock, into the 160x120 VGA frame buffer interface.
- Optionally follows the sprite with a background-colour trail erase: left column, right column or top row, selectable per draw.
- Uses a start/done handshake, an explicit plot strobe and correct screen wrap in both directions.
- Sits between the game FSM/datapath and the VGA adapter; one instance per sprite.

Parameters:
- W, 4, sprite width in pixels (1..16)
- H, 4, sprite height in pixels (1..16)
- SCREEN_W, 160, horizontal wrap modulus
- SCREEN_H, 120, vertical wrap modulus
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- BG_COLOUR, 0, colour used for erase pixels

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort (game restart / space pressed)
- start  in  1  draw request, sampled only in IDLE
- sprite_x  in  XW  sprite left edge
- sprite_y  in  YW  sprite top edge
- colour  in  CW  fill colour
- erase_mode  in  2  00 none, 01 column x-1, 10 column x+W, 11 row y-1
- x_out  out  XW  pixel x
- y_out  out  YW  pixel y
- colour_out  out  CW  pixel colour
- plot  out  1  pixel valid / VGA write enable
- busy  out  1  draw in progress
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs go to 0 and all internal counters/latches are cleared.
- clear=1 (synchronous, priority over everything except reset):
  - state goes to IDLE; plot, busy, done go to 0; x_out/y_out go to 0.
  - Any draw in progress is abandoned with no done pulse.
- States: IDLE, FILL, ERASE, DONE. All outputs are registered.
- IDLE:
  - plot=0, busy=0.
  - start=1 at edge k: latch sprite_x, sprite_y, colour, erase_mode; enter FILL.
  - At that same edge, present fill pixel 0 with plot=1 and busy=1.
- FILL:
  - Column-major order: row index r increments fastest (0..H-1), then column c (0..W-1).
  - Pixel i is presented after edge k+i, with colour_out = latched colour.
  - Takes exactly W*H cycles.
  - After the last fill pixel: go to ERASE if mode≠00, else to DONE.
- ERASE:
  - Modes 01/10: H pixels down the column at x-1 or x+W, rows y..y+H-1.
  - Mode 11: W pixels along row y-1, columns x..x+W-1.
  - colour_out = BG_COLOUR, plot=1.
- DONE:
  - Entered on the edge after the last pixel.
  - plot=0, done=1, busy=0 for exactly one cycle, then IDLE.
  - start is not sampled in DONE; earliest restart is the next cycle.
- Total: N = W*H + E pixels, where E = 0, H or W depending on mode. done is high after edge k+N.
- start while busy is ignored; latched inputs are stable for the whole draw even if the input pins change.
- Wrap arithmetic, with no % operator:
  - x_out = lx+c; subtract SCREEN_W if ≥ SCREEN_W.
  - y_out is wrapped the same way against SCREEN_H.
  - x-1 with lx=0 gives SCREEN_W-1; y-1 with ly=0 gives SCREEN_H-1.
  - Sums are computed one bit wider than XW/YW.
- Input coordinates ≥ the modulus are reduced by one subtraction when latched. Valid for inputs < 2×modulus, which all defaults satisfy.
- x_out/y_out/colour_out hold their last values when plot=0.

Test Plan:
- Reset, then start at (10,20), colour 3'b100, mode 00, W=H=4:
  - 16 plot cycles in order (10,20),(10,21)…(13,23), all colour 4.
  - done pulses once on cycle 17; busy is high for cycles 1-16.
- Start at (10,20), mode 01:
  - After the 16 fill pixels, 4 pixels (9,20..23) with colour 0.
  - done on cycle 21.
- Wrap case: start at (158,118), mode 10:
  - Fill x∈{158,159,0,1}, y∈{118,119,0,1}.
  - Erase column x=2, y∈{118,119,0,1}.
- Start at (0,0), mode 11:
  - Erase row y=119, x=0..3, colour 0.
  - 20 pixels total.
- Assert clear on pixel 7 of a draw: the next cycle has plot=0, busy=0, and done never pulses. Separately, start pulsed mid-draw with new coordinates is ignored: coordinates stay as first latched.
- W=8, H=2, reset asserted asynchronously mid-FILL: outputs go to 0 immediately; a fresh start then produces 16 pixels, column-major.
